cp0_exc_sequencer: RTL and testbench

CP0_EXC_SEQUENCER -- requirements
Module: cp0_exc_sequencer

---
 rtl/cp0_exc_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_cp0_exc_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exc_sequencer.sv
// CP0 exception / ERET / MTC0 sequencer.
// Serialises the CP0 register updates of an exception entry (EPC, optional
// BadVAddr, Cause, Status) and of an ERET (Status) onto one CP0 write port.
// It arbitrates MTC0 requests from WB against those sequences.
// Optional feature: define CP0_BADVADDR_EN to add the BadVAddr write for
// address-error exceptions (codes 4 and 5).
module cp0_exc_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mtc0_en_i,
    input  logic [4:0]  mtc0_addr_i,
    input  logic [31:0] mtc0_data_i,
    output logic        mtc0_ready_o,
    input  logic        exc_valid_i,
    input  logic [4:0]  exc_code_i,
    input  logic [31:0] exc_pc_i,
    input  logic        exc_bd_i,
    input  logic [31:0] exc_badvaddr_i,
    input  logic        eret_valid_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    output logic        cp0_we_o,
    output logic [4:0]  cp0_waddr_o,
    output logic [31:0] cp0_wdata_o,
    output logic        flush_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    output logic        busy_o,
    output logic        int_pending_o
);

    localparam logic [4:0]  ADDR_BADVADDR = 5'd8;
    localparam logic [4:0]  ADDR_STATUS   = 5'd12;
    localparam logic [4:0]  ADDR_CAUSE    = 5'd13;
    localparam logic [4:0]  ADDR_EPC      = 5'd14;
    localparam logic [31:0] EXC_VECTOR    = 32'hBFC0_0380;
    localparam logic [31:0] EXL_MASK      = 32'h0000_0002;

`ifdef CP0_BADVADDR_EN
    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        EXC_EPC     = 3'd1,
        EXC_BADV    = 3'd2,
        EXC_CAUSE   = 3'd3,
        EXC_STATUS  = 3'd4,
        ERET_STATUS = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        EXC_EPC     = 3'd1,
        EXC_CAUSE   = 3'd3,
        EXC_STATUS  = 3'd4,
        ERET_STATUS = 3'd5
    } state_t;
`endif

    state_t      state;
    state_t      state_d;

    // Exception details captured when the sequence starts
    logic [4:0]  code_q;
    logic [31:0] pc_q;
    logic        bd_q;
`ifdef CP0_BADVADDR_EN
    logic [31:0] badvaddr_q;
`else
    logic        unused_badvaddr;
    assign unused_badvaddr = ^exc_badvaddr_i;
`endif

    logic        idle;
    logic        irq_raw;

    assign idle    = (state == IDLE);
    assign busy_o  = ~idle;
    assign irq_raw = status_i[0] & ~status_i[1] & (|(status_i[15:8] & cause_i[15:8]));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Capture the exception report only when a new sequence is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q <= '0;
            pc_q   <= '0;
            bd_q   <= 1'b0;
`ifdef CP0_BADVADDR_EN
            badvaddr_q <= '0;
`endif
        end else if (idle && exc_valid_i) begin
            code_q <= exc_code_i;
            pc_q   <= exc_pc_i;
            bd_q   <= exc_bd_i;
`ifdef CP0_BADVADDR_EN
            badvaddr_q <= exc_badvaddr_i;
`endif
        end
    end

    // Interrupt-pending flag, held low whenever the next cycle is mid-sequence
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_pending_o <= 1'b0;
        end else begin
            int_pending_o <= irq_raw & (state_d == IDLE);
        end
    end

    // Next-state and write-port / redirect outputs
    always_comb begin
        state_d          = state;
        mtc0_ready_o     = 1'b0;
        cp0_we_o         = 1'b0;
        cp0_waddr_o      = '0;
        cp0_wdata_o      = '0;
        flush_o          = 1'b0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = '0;
        case (state)
            IDLE: begin
                if (exc_valid_i) begin
                    state_d = EXC_EPC;
                end else if (eret_valid_i) begin
                    state_d = ERET_STATUS;
                end else if (mtc0_en_i && rst_n) begin
                    // The rst_n term keeps the pass-through quiet while reset is held
                    mtc0_ready_o = 1'b1;
                    cp0_we_o     = 1'b1;
                    cp0_waddr_o  = mtc0_addr_i;
                    cp0_wdata_o  = mtc0_data_i;
                end
            end
            EXC_EPC: begin
                cp0_we_o    = 1'b1;
                cp0_waddr_o = ADDR_EPC;
                cp0_wdata_o = bd_q ? (pc_q - 32'd4) : pc_q;
                flush_o     = 1'b1;
`ifdef CP0_BADVADDR_EN
                state_d     = (code_q == 5'd4 || code_q == 5'd5) ? EXC_BADV : EXC_CAUSE;
`else
                state_d     = EXC_CAUSE;
`endif
            end
`ifdef CP0_BADVADDR_EN
            EXC_BADV: begin
                cp0_we_o    = 1'b1;
                cp0_waddr_o = ADDR_BADVADDR;
                cp0_wdata_o = badvaddr_q;
                state_d     = EXC_CAUSE;
            end
`endif
            EXC_CAUSE: begin
                cp0_we_o    = 1'b1;
                cp0_waddr_o = ADDR_CAUSE;
                cp0_wdata_o = {bd_q, cause_i[30:7], code_q, cause_i[1:0]};
                state_d     = EXC_STATUS;
            end
            EXC_STATUS: begin
                cp0_we_o         = 1'b1;
                cp0_waddr_o      = ADDR_STATUS;
                cp0_wdata_o      = status_i | EXL_MASK;
                redirect_valid_o = 1'b1;
                redirect_pc_o    = EXC_VECTOR;
                state_d          = IDLE;
            end
            ERET_STATUS: begin
                cp0_we_o         = 1'b1;
                cp0_waddr_o      = ADDR_STATUS;
                cp0_wdata_o      = status_i & ~EXL_MASK;
                flush_o          = 1'b1;
                redirect_valid_o = 1'b1;
                redirect_pc_o    = epc_i;
                state_d          = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_sequencer.sv
// Testbench for cp0_exc_sequencer: directed vector table, hand-written
// reset/BadVAddr sequence, then randomized traffic against a pending-write
// queue model. Honours CP0_BADVADDR_EN the same way as the design.
module tb_cp0_exc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mtc0_en;
    logic [4:0]  mtc0_addr;
    logic [31:0] mtc0_data;
    logic        mtc0_ready;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_bd;
    logic [31:0] exc_badvaddr;
    logic        eret_valid;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;
    logic        int_pending;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cp0_exc_sequencer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .mtc0_en_i        (mtc0_en),
        .mtc0_addr_i      (mtc0_addr),
        .mtc0_data_i      (mtc0_data),
        .mtc0_ready_o     (mtc0_ready),
        .exc_valid_i      (exc_valid),
        .exc_code_i       (exc_code),
        .exc_pc_i         (exc_pc),
        .exc_bd_i         (exc_bd),
        .exc_badvaddr_i   (exc_badvaddr),
        .eret_valid_i     (eret_valid),
        .status_i         (status),
        .cause_i          (cause),
        .epc_i            (epc),
        .cp0_we_o         (cp0_we),
        .cp0_waddr_o      (cp0_waddr),
        .cp0_wdata_o      (cp0_wdata),
        .flush_o          (flush),
        .redirect_valid_o (redirect_valid),
        .redirect_pc_o    (redirect_pc),
        .busy_o           (busy),
        .int_pending_o    (int_pending)
    );

    typedef struct packed {
        logic        exc;
        logic [4:0]  code;
        logic [31:0] pc;
        logic        bd;
        logic [31:0] badv;
        logic        eret;
        logic        men;
        logic [4:0]  maddr;
        logic [31:0] mdata;
        logic [31:0] status;
        logic [31:0] cause;
        logic [31:0] epc;
    } in_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        flush;
        logic        rv;
        logic [31:0] rpc;
        logic        busy;
        logic        ready;
        logic        intp;
    } out_t;

    typedef struct packed {
        in_t  in;
        out_t exp;
    } vec_t;

    localparam logic [31:0] VEC = 32'hBFC0_0380;
    localparam logic [31:0] P   = 32'h8000_1000;

    function automatic in_t mk_in(input logic exc, input logic [4:0] code, input logic [31:0] pc,
                                  input logic bd, input logic [31:0] badv, input logic eret,
                                  input logic men, input logic [4:0] maddr, input logic [31:0] mdata,
                                  input logic [31:0] st, input logic [31:0] ca, input logic [31:0] ep);
        return '{exc, code, pc, bd, badv, eret, men, maddr, mdata, st, ca, ep};
    endfunction

    function automatic out_t mk_out(input logic we, input logic [4:0] a, input logic [31:0] d,
                                    input logic fl, input logic rv, input logic [31:0] rpc,
                                    input logic bz, input logic rdy, input logic ip);
        return '{we, a, d, fl, rv, rpc, bz, rdy, ip};
    endfunction

    task automatic apply_in(input in_t v);
        exc_valid    = v.exc;
        exc_code     = v.code;
        exc_pc       = v.pc;
        exc_bd       = v.bd;
        exc_badvaddr = v.badv;
        eret_valid   = v.eret;
        mtc0_en      = v.men;
        mtc0_addr    = v.maddr;
        mtc0_data    = v.mdata;
        status       = v.status;
        cause        = v.cause;
        epc          = v.epc;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input out_t e);
        chk({tag, ".we"},    32'(cp0_we),         32'(e.we));
        chk({tag, ".addr"},  32'(cp0_waddr),      32'(e.addr));
        chk({tag, ".data"},  cp0_wdata,           e.data);
        chk({tag, ".flush"}, 32'(flush),          32'(e.flush));
        chk({tag, ".rv"},    32'(redirect_valid), 32'(e.rv));
        chk({tag, ".rpc"},   redirect_pc,         e.rpc);
        chk({tag, ".busy"},  32'(busy),           32'(e.busy));
        chk({tag, ".ready"}, 32'(mtc0_ready),     32'(e.ready));
        chk({tag, ".int"},   32'(int_pending),    32'(e.intp));
    endtask

    // Reference model: a queue of CP0 writes still owed by the sequencer
    localparam int K_EPC = 0, K_BADV = 1, K_CAUSE = 2, K_STATUS = 3, K_ERET = 4;
    int          q[$];
    logic [4:0]  m_code;
    logic [31:0] m_pc;
    logic [31:0] m_badv;
    logic        m_bd;
    logic        m_int;

    function automatic out_t model_out();
        out_t e = '0;
        if (q.size() == 0) begin
            if (!exc_valid && !eret_valid && mtc0_en) begin
                e.we = 1'b1; e.addr = mtc0_addr; e.data = mtc0_data; e.ready = 1'b1;
            end
        end else begin
            e.busy = 1'b1;
            e.we   = 1'b1;
            case (q[0])
                K_EPC:    begin e.addr = 5'd14; e.data = m_bd ? m_pc - 32'd4 : m_pc; e.flush = 1'b1; end
                K_BADV:   begin e.addr = 5'd8;  e.data = m_badv; end
                K_CAUSE:  begin e.addr = 5'd13; e.data = cause; e.data[31] = m_bd; e.data[6:2] = m_code; end
                K_STATUS: begin e.addr = 5'd12; e.data = status | 32'h2; e.rv = 1'b1; e.rpc = VEC; end
                default:  begin e.addr = 5'd12; e.data = status & ~32'h2; e.flush = 1'b1;
                                e.rv = 1'b1; e.rpc = epc; end
            endcase
        end
        e.intp = m_int;
        return e;
    endfunction

    task automatic model_advance();
        logic raw;
        raw = status[0] && !status[1] && ((status[15:8] & cause[15:8]) != 8'h00);
        if (q.size() != 0) begin
            void'(q.pop_front());
        end else if (exc_valid) begin
            m_code = exc_code; m_pc = exc_pc; m_bd = exc_bd; m_badv = exc_badvaddr;
            q.push_back(K_EPC);
`ifdef CP0_BADVADDR_EN
            if (exc_code == 5'd4 || exc_code == 5'd5) q.push_back(K_BADV);
`endif
            q.push_back(K_CAUSE);
            q.push_back(K_STATUS);
        end else if (eret_valid) begin
            q.push_back(K_ERET);
        end
        m_int = raw && (q.size() == 0);
    endtask

    vec_t vec[16];
    in_t  zero_in;

    initial begin
        zero_in = '0;

        vec[0]  = '{mk_in(1, 8, P, 0, 0, 0, 1, 11, 32'h1234, 0, 0, 0),     mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0)};
        vec[1]  = '{mk_in(0, 0, 0, 0, 0, 0, 1, 11, 32'h1234, 0, 0, 0),     mk_out(1, 14, P, 1, 0, 0, 1, 0, 0)};
        vec[2]  = '{mk_in(1, 3, 0, 0, 0, 1, 1, 11, 32'h1234, 0, 0, 0),     mk_out(1, 13, 32'h20, 0, 0, 0, 1, 0, 0)};
        vec[3]  = '{mk_in(0, 0, 0, 0, 0, 0, 1, 11, 32'h1234, 0, 0, 0),     mk_out(1, 12, 32'h2, 0, 1, VEC, 1, 0, 0)};
        vec[4]  = '{mk_in(0, 0, 0, 0, 0, 0, 1, 11, 32'h1234, 0, 0, 0),     mk_out(1, 11, 32'h1234, 0, 0, 0, 0, 1, 0)};
        vec[5]  = '{mk_in(1, 8, P, 1, 0, 0, 0, 0, 0, 0, 0, 0),             mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0)};
        vec[6]  = '{zero_in,                                                mk_out(1, 14, 32'h8000_0FFC, 1, 0, 0, 1, 0, 0)};
        vec[7]  = '{zero_in,                                                mk_out(1, 13, 32'h8000_0020, 0, 0, 0, 1, 0, 0)};
        vec[8]  = '{zero_in,                                                mk_out(1, 12, 32'h2, 0, 1, VEC, 1, 0, 0)};
        vec[9]  = '{mk_in(0, 0, 0, 0, 0, 1, 0, 0, 0, 32'hFF03, 0, 32'h8000_2000), mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0)};
        vec[10] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hFF03, 0, 32'h8000_2000),
                    mk_out(1, 12, 32'hFF01, 1, 1, 32'h8000_2000, 1, 0, 0)};
        vec[11] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hFF03, 0, 0),      mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0)};
        vec[12] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hFF01, 32'h100, 0), mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0)};
        vec[13] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hFF01, 32'h100, 0), mk_out(0, 0, 0, 0, 0, 0, 0, 0, 1)};
        vec[14] = '{zero_in,                                                mk_out(0, 0, 0, 0, 0, 0, 0, 0, 1)};
        vec[15] = '{zero_in,                                                mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0)};

        // Reset held with an MTC0 request pending: everything must stay quiet
        rst_n = 1'b0;
        apply_in(mk_in(0, 0, 0, 0, 0, 0, 1, 11, 32'h1234, 0, 0, 0));
        @(negedge clk);
        @(negedge clk);
        check_out("reset", '0);
        rst_n = 1'b1;
        apply_in(zero_in);

        // Directed vector table
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            apply_in(vec[i].in);
            #1;
            check_out($sformatf("vec%0d", i), vec[i].exp);
        end

        // Address-error exception, then reset in the middle of the Cause write
        @(negedge clk);
        apply_in(mk_in(1, 4, 32'h8000_3000, 0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0));
        #1;
        check_out("ae_accept", '0);
        @(negedge clk);
        apply_in(zero_in);
        #1;
        check_out("ae_epc", mk_out(1, 14, 32'h8000_3000, 1, 0, 0, 1, 0, 0));
`ifdef CP0_BADVADDR_EN
        @(negedge clk);
        #1;
        check_out("ae_badv", mk_out(1, 8, 32'hDEAD_BEEF, 0, 0, 0, 1, 0, 0));
`endif
        @(negedge clk);
        apply_in(mk_in(0, 0, 0, 0, 0, 0, 1, 11, 32'h1234, 0, 0, 0));
        #1;
        check_out("ae_cause", mk_out(1, 13, 32'h10, 0, 0, 0, 1, 0, 0));
        rst_n = 1'b0;
        #1;
        check_out("ae_midrst", '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_out("post_rst_mtc0", mk_out(1, 11, 32'h1234, 0, 0, 0, 0, 1, 0));
        @(negedge clk);
        apply_in(zero_in);
        #1;
        check_out("no_resume", '0);

        // Randomized traffic against the pending-write model
        q.delete();
        m_int = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst_n        = 1'b1;
            exc_valid    = ($urandom_range(0, 5) == 0);
            exc_code     = ($urandom_range(0, 3) == 0) ? 5'(4 + $urandom_range(0, 1)) : 5'($urandom_range(0, 31));
            exc_pc       = $urandom;
            exc_bd       = 1'($urandom_range(0, 1));
            exc_badvaddr = $urandom;
            eret_valid   = ($urandom_range(0, 5) == 0);
            mtc0_en      = 1'($urandom_range(0, 1));
            mtc0_addr    = 5'($urandom_range(0, 31));
            mtc0_data    = $urandom;
            status       = $urandom;
            cause        = $urandom;
            epc          = $urandom;
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                #1;
                check_out($sformatf("rnd_rst%0d", i), '0);
                q.delete();
                m_int = 1'b0;
            end else begin
                #1;
                check_out($sformatf("rnd%0d", i), model_out());
                model_advance();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
